// File: rtl/seq_slice_adder_ctrl.sv
// Sequential N-bit adder built from one W-bit slice, LSB chunk first, with valid/ready on both sides.
// Optional build macro SEQ_SLICE_ADDER_SUB_EN adds a 'sub' input for a - b (c_out=1 means no borrow).
module seq_slice_adder_ctrl #(
    parameter int N = 64,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef SEQ_SLICE_ADDER_SUB_EN
    input  logic         sub,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         busy
);

    localparam int CHUNKS = N / W;
    localparam int CNT_W  = $clog2(CHUNKS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic               armed;
    logic [CNT_W-1:0]   cnt;
    logic [N-1:0]       a_sh, b_sh, res;
    logic               carry, cout_q;
    logic [W:0]         slice;
    logic [N-1:0]       b_load;
    logic               carry_load;
    logic               accept, last;

`ifdef SEQ_SLICE_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; the caller's c_in is discarded in that mode.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub | c_in;
`else
    assign b_load     = b;
    assign carry_load = c_in;
`endif

    assign slice  = {1'b0, a_sh[W-1:0]} + {1'b0, b_sh[W-1:0]} + {{W{1'b0}}, carry};
    assign last   = (state == RUN) && (cnt == CNT_W'(CHUNKS - 1));
    assign accept = in_valid && in_ready;
    assign sum    = res;
    assign c_out  = cout_q;

    // 'armed' keeps in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = armed;
                if (in_valid && armed) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the datapath registers are cleared on reset so an aborted operation never leaves a partial sum visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> W;
            b_sh  <= b_sh >> W;
            res   <= (res >> W) | (N'(slice[W-1:0]) << (N - W));
            carry <= slice[W];
            cnt   <= cnt + 1'b1;
            if (last) cout_q <= slice[W];
        end
    end

endmodule

// File: tb/tb_seq_slice_adder_ctrl.sv
// Directed bench for seq_slice_adder_ctrl: N=16/W=4 instance plus an N=W=8 instance.
// Define SEQ_SLICE_ADDER_SUB_EN to also exercise subtraction.
module tb_seq_slice_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 0, out_ready = 0, c_in = 0, sub = 0;
    logic [15:0] a = 0, b = 0;
    logic        in_ready, out_valid, c_out, busy;
    logic [15:0] sum;

    logic        in_valid8 = 0, out_ready8 = 0, c_in8 = 0, sub8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        in_ready8, out_valid8, c_out8, busy8;
    logic [7:0]  sum8;

    int total = 0;
    int bad   = 0;

    seq_slice_adder_ctrl #(.N(16), .W(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
`ifdef SEQ_SLICE_ADDER_SUB_EN
        .sub(sub),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out), .busy(busy)
    );

    seq_slice_adder_ctrl #(.N(8), .W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
`ifdef SEQ_SLICE_ADDER_SUB_EN
        .sub(sub8),
`endif
        .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .c_in(c_in8),
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .c_out(c_out8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;
    logic seen;

    initial begin
        // Reset state while rst_n is low
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_before_edge", in_ready, 0);
        tick();
        check("rel_in_ready_after_edge", in_ready, 1);

        // 1: 0xFFFF + 0x0001, latency CHUNKS=4
        a = 16'hFFFF; b = 16'h0001; c_in = 0; in_valid = 1;
        tick();
        in_valid = 0;
        check("t1_busy", busy, 1);
        check("t1_in_ready_run", in_ready, 0);
        tick(); tick(); tick();
        check("t1_out_valid_early", out_valid, 0);
        tick();
        check("t1_out_valid", out_valid, 1);
        check("t1_sum", sum, 16'h0000);
        check("t1_c_out", c_out, 1);
        check("t1_in_ready_done", in_ready, 0);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("t1_idle_out_valid", out_valid, 0);
        check("t1_idle_in_ready", in_ready, 1);
        check("t1_idle_busy", busy, 0);

        // 2: 0x1234 + 0x4321 + 1, consumer stalls 10 cycles, stray in_valid pulses
        a = 16'h1234; b = 16'h4321; c_in = 1; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (4) tick();
        check("t2_out_valid", out_valid, 1);
        check("t2_sum", sum, 16'h5556);
        check("t2_c_out", c_out, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 16'hAAAA; b = 16'h1111; c_in = 0;
            tick();
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_sum", sum, 16'h5556);
            check("t2_hold_c_out", c_out, 0);
            check("t2_hold_in_ready", in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
        check("t2_ret_in_ready", in_ready, 1);
        check("t2_ret_out_valid", out_valid, 0);
        check("t2_sum_kept", sum, 16'h5556);
        tick();
        check("t2_no_stray_accept", busy, 0);

        // 3: async reset during the 2nd RUN cycle
        a = 16'hFFFF; b = 16'hFFFF; c_in = 0; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        check("t3_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t3_rst_busy", busy, 0);
        check("t3_rst_in_ready", in_ready, 0);
        check("t3_rst_out_valid", out_valid, 0);
        check("t3_rst_sum", sum, 0);
        check("t3_rst_c_out", c_out, 0);
        #1 rst_n = 1'b1;
        #1;
        check("t3_rel_in_ready", in_ready, 0);
        tick();
        check("t3_rel_in_ready_edge", in_ready, 1);
        check("t3_no_partial", out_valid, 0);
        a = 16'h0003; b = 16'h0004; c_in = 0; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (3) tick();
        check("t3_out_valid_early", out_valid, 0);
        tick();
        check("t3_out_valid", out_valid, 1);
        check("t3_sum", sum, 16'h0007);
        check("t3_c_out", c_out, 0);
        out_ready = 1;
        tick();

        // 4: back-to-back with in_valid and out_ready held high
        a = 16'h8000; b = 16'h8000; c_in = 0; in_valid = 1; out_ready = 1;
        check("t4_ready_first", in_ready, 1);
        tick();
        a = 16'h00FF; b = 16'h0001;
        n = 0; seen = 0;
        while (!in_ready && n < 20) begin
            if (out_valid) begin
                seen = 1;
                check("t4_sum1", sum, 16'h0000);
                check("t4_c_out1", c_out, 1);
            end
            tick();
            n++;
        end
        check("t4_first_result_seen", seen, 1);
        check("t4_interval", n + 1, 6);
        tick();
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("t4_latency2", n, 4);
        check("t4_sum2", sum, 16'h0100);
        check("t4_c_out2", c_out, 0);
        tick();
        out_ready = 0;
        check("t4_idle", busy, 0);

        // 5: N=W=8, single RUN cycle
        a8 = 8'hAA; b8 = 8'h55; c_in8 = 1; in_valid8 = 1;
        check("t5_ready", in_ready8, 1);
        tick();
        in_valid8 = 0;
        check("t5_busy", busy8, 1);
        check("t5_valid_early", out_valid8, 0);
        tick();
        check("t5_out_valid", out_valid8, 1);
        check("t5_sum", sum8, 8'h00);
        check("t5_c_out", c_out8, 1);
        out_ready8 = 1;
        tick();
        out_ready8 = 0;
        check("t5_idle", in_ready8, 1);

`ifdef SEQ_SLICE_ADDER_SUB_EN
        // 6: subtraction, c_in must be ignored
        sub = 1; c_in = 1; a = 16'h0005; b = 16'h0007; in_valid = 1;
        tick();
        in_valid = 0; sub = 0;
        repeat (4) tick();
        check("t6_valid_a", out_valid, 1);
        check("t6_sum_a", sum, 16'hFFFE);
        check("t6_c_out_a", c_out, 0);
        out_ready = 1;
        tick();
        out_ready = 0;
        sub = 1; c_in = 1; a = 16'h0007; b = 16'h0005; in_valid = 1;
        tick();
        in_valid = 0; sub = 0;
        repeat (4) tick();
        check("t6_valid_b", out_valid, 1);
        check("t6_sum_b", sum, 16'h0002);
        check("t6_c_out_b", c_out, 1);
        out_ready = 1;
        tick();
        out_ready = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_slice_adder_ctrl.md
Name: seq_slice_adder_ctrl

Overview:
- Sequencer that computes an N-bit add using one W-bit adder slice, one chunk per clock.
- Operands are processed LSB chunk first. A registered carry is passed from each chunk to the next.
- Trades latency for area compared with a full-width registered ripple adder.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- N, 64, operand/result width in bits. Must be an integer multiple of W.
- W, 8, slice width in bits. 1 <= W <= N.
- CHUNKS (localparam), N/W, number of slice cycles per operation.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has an operand pair on a/b/c_in.
- in_ready  out  1  block can accept an operand pair.
- a  in  N  operand A.
- b  in  N  operand B.
- c_in  in  1  carry into bit 0.
- out_valid  out  1  sum/c_out hold a completed result.
- out_ready  in  1  consumer accepts the result.
- sum  out  N  registered result.
- c_out  out  1  registered carry out of bit N-1.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): FSM goes to IDLE.
  - in_ready=0 while rst_n is low; in_ready=1 from the first edge after release.
  - out_valid=0, busy=0, sum=0, c_out=0.
  - Chunk counter, operand shift registers and carry register all clear to 0.
  - Reset asserted mid-operation aborts it; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid & in_ready at an edge: capture a into A_sh, b into B_sh, c_in into carry; cnt<=0; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: slice sum {co, s[W-1:0]} = A_sh[W-1:0] + B_sh[W-1:0] + carry.
  - Then: A_sh and B_sh shift right by W; the result register shifts right by W with s entering at [N-1:N-W]; carry<=co; cnt<=cnt+1.
  - On the edge where cnt==CHUNKS-1: c_out<=co and go to DONE.
  - After CHUNKS edges, sum[W*k+W-1:W*k] holds chunk k.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - sum and c_out held stable while out_ready=0, indefinitely.
  - On out_valid & out_ready at an edge: out_valid<=0 and go to IDLE.
  - sum and c_out keep their last value after the handshake until overwritten by the next operation.
- Latency:
  - Operand accepted at edge k; out_valid rises after edge k+CHUNKS.
  - Minimum initiation interval is CHUNKS+2 cycles: accept, CHUNKS run edges, one DONE handshake cycle, return to IDLE.
- Handshake rules:
  - in_valid while busy is ignored; the producer must hold it until in_ready.
  - a, b and c_in are sampled only at the accepting edge.
  - out_valid never drops without out_ready.
- Width rules:
  - All arithmetic is unsigned modulo 2^N; c_out is the true carry out.
  - W==N: CHUNKS=1, one RUN cycle.
  - W==1: bit-serial operation.
- The counter is ceil(log2(CHUNKS+1)) bits wide and never wraps within a legal operation.

Optional Feature:
- Macro: SEQ_SLICE_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled at accept together with a/b/c_in.
  - sub=1: B_sh captures ~b and carry captures 1, so the result is a-b mod 2^N; c_in is ignored.
  - c_out=1 means no borrow (a>=b).
  - sub=0 behaves exactly as the base block.
- Undefined:
  - No sub port; addition only.
  - Identical timing in both builds.

Test Plan:
1. N=16, W=4, reset then a=0xFFFF, b=0x0001, c_in=0 accepted at edge k:
   - out_valid high after edge k+4.
   - sum=0x0000, c_out=1, in_ready=0 until out_ready handshake.
2. a=0x1234, b=0x4321, c_in=1, with out_ready held 0 for 10 cycles:
   - sum=0x5556, c_out=0, stable throughout.
   - in_valid pulses meanwhile are ignored.
   - Return to IDLE one edge after out_ready=1.
3. Assert rst_n=0 asynchronously in the 2nd RUN cycle:
   - All outputs are 0 immediately.
   - After release, a=0x0003, b=0x0004 gives sum=0x0007 with normal latency.
4. Back-to-back:
   - Hold in_valid=1 and out_ready=1 with operand pairs (0x8000,0x8000) then (0x00FF,0x0001).
   - Results are 0x0000/c_out=1 then 0x0100/c_out=0.
   - The second operand pair is accepted exactly CHUNKS+2 cycles after the first.
5. N=W=8: a=0xAA, b=0x55, c_in=1 gives sum=0x00, c_out=1, with out_valid one edge after accept.
6. With SEQ_SLICE_ADDER_SUB_EN, N=16, W=4:
   - sub=1, a=0x0005, b=0x0007 gives sum=0xFFFE, c_out=0.
   - sub=1, a=0x0007, b=0x0005 gives sum=0x0002, c_out=1.
